// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction-fetch front end. Owns the PC, drives the
//            combinational instruction ROM and fills the IF/ID pipeline slot.
//            Supports sequential fetch, delay-slot branch redirection,
//            fetch/decode stalls with branch deferral, flush redirect and
//            misaligned-fetch flagging.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
  parameter int                PC_WIDTH   = 32,
  parameter int                INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_if,
  input  logic                  stall_id,
  input  logic                  branch_flag,
  input  logic [PC_WIDTH-1:0]   branch_target,
  input  logic                  flush,
  input  logic [PC_WIDTH-1:0]   new_pc,
  input  logic [INST_WIDTH-1:0] rom_inst,
  output logic                  rom_ce,
  output logic [PC_WIDTH-1:0]   rom_addr,
  output logic [PC_WIDTH-1:0]   id_pc,
  output logic [INST_WIDTH-1:0] id_inst,
  output logic                  id_valid,
  output logic                  id_exc_adel
);

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic [1:0]          state;
  logic [PC_WIDTH-1:0] pc;
  logic                pend_valid;
  logic [PC_WIDTH-1:0] pend_target;

  logic                hold;       // effective fetch stall (decode stall implies it)
  logic                misaligned;
  logic [PC_WIDTH-1:0] next_pc;

  // Stall qualification, alignment check and sequential/redirect PC selection
  always_comb begin
    hold       = stall_if | stall_id;
    misaligned = (pc[1:0] != 2'b00);
    if (branch_flag) begin
      next_pc = branch_target;
    end else if (pend_valid) begin
      next_pc = pend_target;
    end else begin
      next_pc = pc + PC_WIDTH'(4);
    end
  end

  assign rom_addr = pc;

  // Fetch state machine, PC, deferred branch and IF/ID slot update
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESET;
      rom_ce      <= 1'b0;
      pc          <= RESET_PC;
      id_pc       <= '0;
      id_inst     <= '0;
      id_valid    <= 1'b0;
      id_exc_adel <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (state == S_RESET) begin
      // First cycle out of reset: enable the ROM at RESET_PC, capture nothing.
      state  <= S_RUN;
      rom_ce <= 1'b1;
    end else if (flush) begin
      // Flush beats stalls and branches; any deferred branch is dropped.
      state       <= S_RUN;
      rom_ce      <= 1'b1;
      pc          <= new_pc;
      id_pc       <= '0;
      id_inst     <= '0;
      id_valid    <= 1'b0;
      id_exc_adel <= 1'b0;
      pend_valid  <= 1'b0;
    end else if (hold) begin
      state <= S_STALL;
      // A branch resolved while fetch is frozen is remembered; latest wins.
      if (branch_flag) begin
        pend_valid  <= 1'b1;
        pend_target <= branch_target;
      end
      // Decode still moving: feed it a bubble. Decode stalled: keep the slot.
      if (!stall_id) begin
        id_pc       <= '0;
        id_inst     <= '0;
        id_valid    <= 1'b0;
        id_exc_adel <= 1'b0;
      end
    end else begin
      // Advance: current word (delay slot included) enters IF/ID.
      state       <= S_RUN;
      id_pc       <= pc;
      id_inst     <= misaligned ? '0 : rom_inst;
      id_valid    <= 1'b1;
      id_exc_adel <= misaligned;
      pc          <= next_pc;
      if (!branch_flag) begin
        pend_valid <= 1'b0;
      end else if (pend_valid) begin
        // A fresh branch supersedes the deferred one, which is then stale.
        pend_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Directed self-checking bench for inst_fetch.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if;
  logic        stall_id;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] rom_inst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_exc_adel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // ROM model: upper half constant tag, lower half the address.
  assign rom_inst = {16'hC0DE, rom_addr[15:0]};

  inst_fetch #(
    .PC_WIDTH  (32),
    .INST_WIDTH(32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .flush        (flush),
    .new_pc       (new_pc),
    .rom_inst     (rom_inst),
    .rom_ce       (rom_ce),
    .rom_addr     (rom_addr),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid),
    .id_exc_adel  (id_exc_adel)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    branch_flag   = 1'b0;
    branch_target = 32'h0;
    flush         = 1'b0;
    new_pc        = 32'h0;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush  = 1'b1;
    new_pc = pc;
    tick();
    flush  = 1'b0;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] addr,
                        input logic [31:0] pc, input logic [31:0] inst,
                        input logic vld, input logic adel);
    check_value({tag, ".rom_addr"}, rom_addr, addr);
    check_value({tag, ".id_pc"},    id_pc,    pc);
    check_value({tag, ".id_inst"},  id_inst,  inst);
    check_value({tag, ".id_valid"}, {31'b0, id_valid},    {31'b0, vld});
    check_value({tag, ".id_adel"},  {31'b0, id_exc_adel}, {31'b0, adel});
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    check_value("rst.rom_ce", {31'b0, rom_ce}, 32'h0);
    chk_if("rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset release and sequential fetch
    rst = 1'b0;
    tick();
    check_value("rel.rom_ce", {31'b0, rom_ce}, 32'h1);
    chk_if("rel0", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick(); chk_if("seq1", 32'h4, 32'h0, 32'hC0DE_0000, 1'b1, 1'b0);
    tick(); chk_if("seq2", 32'h8, 32'h4, 32'hC0DE_0004, 1'b1, 1'b0);
    tick(); chk_if("seq3", 32'hC, 32'h8, 32'hC0DE_0008, 1'b1, 1'b0);

    // Branch with delay slot at 0x0C
    branch_flag = 1'b1; branch_target = 32'h100;
    tick(); chk_if("br0", 32'h100, 32'hC, 32'hC0DE_000C, 1'b1, 1'b0);
    branch_flag = 1'b0;
    tick(); chk_if("br1", 32'h104, 32'h100, 32'hC0DE_0100, 1'b1, 1'b0);

    // Stall split at 0x20
    do_flush(32'h20);
    chk_if("fl20", 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
    stall_if = 1'b1;
    tick(); chk_if("ss0", 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
    tick(); chk_if("ss1", 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
    stall_if = 1'b0;
    tick(); chk_if("ssr", 32'h24, 32'h20, 32'hC0DE_0020, 1'b1, 1'b0);

    // Pending branch during full stall at 0x40
    do_flush(32'h3C);
    tick(); chk_if("pb_pre", 32'h40, 32'h3C, 32'hC0DE_003C, 1'b1, 1'b0);
    stall_if = 1'b1; stall_id = 1'b1;
    branch_flag = 1'b1; branch_target = 32'h200;
    tick(); chk_if("pb0", 32'h40, 32'h3C, 32'hC0DE_003C, 1'b1, 1'b0);
    branch_flag = 1'b0;
    tick(); chk_if("pb1", 32'h40, 32'h3C, 32'hC0DE_003C, 1'b1, 1'b0);
    stall_if = 1'b0; stall_id = 1'b0;
    tick(); chk_if("pbr", 32'h200, 32'h40, 32'hC0DE_0040, 1'b1, 1'b0);
    tick(); chk_if("pbn", 32'h204, 32'h200, 32'hC0DE_0200, 1'b1, 1'b0);

    // Illegal decode-only stall behaves as a full stall
    stall_id = 1'b1;
    tick(); chk_if("sid", 32'h204, 32'h200, 32'hC0DE_0200, 1'b1, 1'b0);
    stall_id = 1'b0;

    // Flush over stall clears a deferred branch
    stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h300;
    tick(); chk_if("fs_pend", 32'h204, 32'h0, 32'h0, 1'b0, 1'b0);
    branch_flag = 1'b0;
    flush = 1'b1; new_pc = 32'h180;
    tick(); chk_if("fs0", 32'h180, 32'h0, 32'h0, 1'b0, 1'b0);
    flush = 1'b0; stall_if = 1'b0;
    tick(); chk_if("fs1", 32'h184, 32'h180, 32'hC0DE_0180, 1'b1, 1'b0);

    // Misaligned fetch address
    do_flush(32'h182);
    check_value("mis.rom_addr", rom_addr, 32'h182);
    tick(); chk_if("mis1", 32'h186, 32'h182, 32'h0, 1'b1, 1'b1);

    // PC wrap
    do_flush(32'hFFFF_FFFC);
    check_value("wrap.rom_addr", rom_addr, 32'hFFFF_FFFC);
    tick(); chk_if("wrap1", 32'h0, 32'hFFFF_FFFC, 32'hC0DE_FFFC, 1'b1, 1'b0);

    // Reset wins over flush
    rst = 1'b1; flush = 1'b1; new_pc = 32'h500;
    tick();
    check_value("rf.rom_ce", {31'b0, rom_ce}, 32'h0);
    chk_if("rf", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch front end: owns the program counter, drives chip-enable and address to the combinational instruction ROM, and registers the returned word into the IF/ID pipeline slot for the decode stage.
- Handles sequential fetch, branch redirection (ID-resolved, delay-slot preserving), pipeline stall/bubble control, exception flush redirect, and misaligned-fetch flagging.

Parameters:
- PC_WIDTH, 32, width of PC and all address ports
- INST_WIDTH, 32, instruction word width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- stall_if  input  1  hold PC (fetch stage stalled)
- stall_id  input  1  hold IF/ID slot (decode stalled)
- branch_flag  input  1  ID resolved a taken branch/jump this cycle
- branch_target  input  PC_WIDTH  redirect address accompanying branch_flag
- flush  input  1  exception/eret flush from control
- new_pc  input  PC_WIDTH  redirect address accompanying flush
- rom_inst  input  INST_WIDTH  word returned combinationally by ROM for rom_addr
- rom_ce  output  1  ROM chip enable
- rom_addr  output  PC_WIDTH  current PC (byte address)
- id_pc  output  PC_WIDTH  PC of instruction in IF/ID slot
- id_inst  output  INST_WIDTH  instruction in IF/ID slot
- id_valid  output  1  IF/ID slot holds a real instruction
- id_exc_adel  output  1  slot instruction came from a misaligned PC

Behaviour:
- All state updates on posedge clk; rst overrides everything.
- Reset: state=S_RESET, rom_ce=0, rom_addr=RESET_PC, id_pc=0, id_inst=0, id_valid=0, id_exc_adel=0, pend_valid=0, pend_target=0.
- FSM: S_RESET -> S_RUN on first cycle with rst=0 (sets rom_ce=1, PC stays RESET_PC). S_RUN -> S_STALL when stall_if=1 and flush=0. S_STALL -> S_RUN when stall_if=0 or flush=1. rst from any state -> S_RESET.
- In S_RESET nothing is captured; id_valid stays 0.
- Advance (S_RUN/S_STALL, stall_if=0, flush=0): id_pc<=rom_addr; id_inst<=rom_inst; id_valid<=1; id_exc_adel<=(rom_addr[1:0]!=0); if misaligned id_inst<=0. PC<=next_pc.
- next_pc priority: branch_flag -> branch_target; else pend_valid -> pend_target (pend_valid<=0); else PC+4, modulo 2^PC_WIDTH (FFFF_FFFC wraps to 0).
- Branch latency: branch_flag in cycle N (delay-slot instruction at rom_addr in N) -> rom_addr=branch_target in N+1; delay slot is captured into IF/ID, never squashed.
- stall_if=1, stall_id=0: PC holds; IF/ID receives bubble (id_valid=0, id_inst=0, id_pc=0, id_exc_adel=0).
- stall_if=1, stall_id=1: PC and IF/ID both hold.
- stall_id=1, stall_if=0: illegal; treated as stall_if=stall_id=1.
- branch_flag while stall_if=1: pend_valid<=1, pend_target<=branch_target (later branch overwrites earlier); applied at next advance.
- flush: highest priority, overrides stalls and branches: PC<=new_pc, IF/ID cleared to bubble, pend_valid<=0, state<=S_RUN, rom_ce=1. new_pc misalignment is flagged only when that PC is captured.
- flush and rst together: rst wins.
- rom_ce deasserts only in reset; rom_addr changes only on advance or flush.
- Outputs are registered; no combinational path from inputs to rom_addr/id_*.

Test Plan:
- Reset release, no stalls: rst high 3 cycles then low -> rom_ce=1 in first cycle after release with rom_addr=0; then 4, 8, C; id_pc trails rom_addr by one cycle, id_valid=1 from the second post-reset cycle.
- Branch with delay slot: branch_flag=1, branch_target=0x100 while rom_addr=0x0C -> next rom_addr=0x100, id_pc=0x0C (delay slot) valid, then id_pc=0x100.
- Stall split: stall_if=1, stall_id=0 for 2 cycles at rom_addr=0x20 -> rom_addr holds 0x20, id_valid=0 both cycles; release -> id_pc=0x20, rom_addr=0x24.
- Pending branch: stall_if=stall_id=1, branch_flag pulse target=0x200 at rom_addr=0x40 -> IF/ID holds; on release id_pc=0x40, rom_addr=0x200.
- Flush over stall: stall_if=1, flush=1, new_pc=0x180 -> rom_addr=0x180, id_valid=0, pend cleared; new_pc=0x182 -> capture gives id_exc_adel=1, id_inst=0.
- Wrap: PC forced via flush to 0xFFFF_FFFC -> next rom_addr=0x0000_0000.
